// File: rtl/mips_pkg.sv
// Shared encodings for the 16-bit multicycle MIPS-style datapath: ALU codes,
// opcodes, operand-select encodings and the control FSM state type.
package mips_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_PASS = 4'b0000;

    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_ADDI  = 4'b0001;
    localparam logic [3:0] OP_LW    = 4'b0010;
    localparam logic [3:0] OP_SW    = 4'b0011;
    localparam logic [3:0] OP_BEQ   = 4'b0100;
    localparam logic [3:0] OP_J     = 4'b0101;

    localparam logic [2:0] FN_ADD = 3'b000;
    localparam logic [2:0] FN_SUB = 3'b001;
    localparam logic [2:0] FN_SLT = 3'b010;

    localparam logic [1:0] SRC_B_REG    = 2'b00;
    localparam logic [1:0] SRC_B_TWO    = 2'b01;
    localparam logic [1:0] SRC_B_IMM    = 2'b10;
    localparam logic [1:0] SRC_B_IMM_SH = 2'b11;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        ST_FETCH   = 4'd0,
        ST_DECODE  = 4'd1,
        ST_EXEC_R  = 4'd2,
        ST_WB_R    = 4'd3,
        ST_EXEC_I  = 4'd4,
        ST_WB_I    = 4'd5,
        ST_ADDR    = 4'd6,
        ST_MEM_RD  = 4'd7,
        ST_WB_MEM  = 4'd8,
        ST_MEM_WR  = 4'd9,
        ST_BRANCH  = 4'd10,
        ST_JUMP    = 4'd11,
        ST_ILLEGAL = 4'd12
    } state_e;

    // An instruction retires in its last state; a store only once memory accepts it.
    function automatic logic is_retire(input state_e st, input logic mem_ready);
        logic r;
        case (st)
            ST_WB_R, ST_WB_I, ST_WB_MEM, ST_BRANCH, ST_JUMP: r = 1'b1;
            ST_MEM_WR: r = mem_ready;
            default:   r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mc_alu_dec.sv
// R-type function decoder: maps funct to the ALU control code and flags
// function values the ALU does not implement.
module mc_alu_dec
    import mips_pkg::*;
(
    input  logic [2:0] funct_i,
    output logic [3:0] alu_ctrl_o,
    output logic       illegal_o
);

    // Pure lookup; unknown functions fall back to pass-A and raise illegal.
    always_comb begin
        alu_ctrl_o = ALU_PASS;
        illegal_o  = 1'b0;
        case (funct_i)
            FN_ADD:  alu_ctrl_o = ALU_ADD;
            FN_SUB:  alu_ctrl_o = ALU_SUB;
            FN_SLT:  alu_ctrl_o = ALU_SLT;
            default: illegal_o  = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multicycle control FSM: sequences fetch/decode/execute/memory/writeback,
// drives ALU and operand selects, counts retired instructions.
module mc_ctrl
    import mips_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [3:0]       op_i,
    input  logic [2:0]       funct_i,
    input  logic             zero_i,
    input  logic             mem_ready_i,
    output logic             mem_req_o,
    output logic             mem_we_o,
    output logic             iord_o,
    output logic             ir_write_o,
    output logic             pc_write_o,
    output logic [1:0]       pc_src_o,
    output logic             alu_src_a_o,
    output logic [1:0]       alu_src_b_o,
    output logic [3:0]       alu_ctrl_o,
    output logic             reg_write_o,
    output logic             reg_dst_o,
    output logic             mem_to_reg_o,
    output logic             err_o,
    output logic [CNT_W-1:0] instr_cnt_o
);

    state_e           state_r;
    state_e           next_s;
    logic [CNT_W-1:0] cnt_r;
    logic [3:0]       dec_alu_s;
    logic             dec_illegal_s;
    logic             retire_s;

    mc_alu_dec u_alu_dec (
        .funct_i    (funct_i),
        .alu_ctrl_o (dec_alu_s),
        .illegal_o  (dec_illegal_s)
    );

    assign retire_s    = is_retire(state_r, mem_ready_i);
    assign instr_cnt_o = cnt_r;

    // State register and retired-instruction counter; counter wraps silently.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= ST_FETCH;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            state_r <= next_s;
            if (retire_s) begin
                cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // Next-state logic; memory states hold until the request completes.
    always_comb begin
        next_s = state_r;
        case (state_r)
            ST_FETCH:  next_s = mem_ready_i ? ST_DECODE : ST_FETCH;
            ST_DECODE: begin
                case (op_i)
                    OP_RTYPE:     next_s = dec_illegal_s ? ST_ILLEGAL : ST_EXEC_R;
                    OP_ADDI:      next_s = ST_EXEC_I;
                    OP_LW, OP_SW: next_s = ST_ADDR;
                    OP_BEQ:       next_s = ST_BRANCH;
                    OP_J:         next_s = ST_JUMP;
                    default:      next_s = ST_ILLEGAL;
                endcase
            end
            ST_EXEC_R: next_s = ST_WB_R;
            ST_EXEC_I: next_s = ST_WB_I;
            ST_ADDR:   next_s = (op_i == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
            ST_MEM_RD: next_s = mem_ready_i ? ST_WB_MEM : ST_MEM_RD;
            ST_MEM_WR: next_s = mem_ready_i ? ST_FETCH : ST_MEM_WR;
            ST_WB_R, ST_WB_I, ST_WB_MEM, ST_BRANCH, ST_JUMP, ST_ILLEGAL:
                       next_s = ST_FETCH;
            default:   next_s = ST_FETCH;
        endcase
    end

    // Control outputs decoded from the state register; all low while in reset.
    always_comb begin
        mem_req_o    = 1'b0;
        mem_we_o     = 1'b0;
        iord_o       = 1'b0;
        ir_write_o   = 1'b0;
        pc_write_o   = 1'b0;
        pc_src_o     = PC_SRC_ALU;
        alu_src_a_o  = 1'b0;
        alu_src_b_o  = SRC_B_REG;
        alu_ctrl_o   = ALU_PASS;
        reg_write_o  = 1'b0;
        reg_dst_o    = 1'b0;
        mem_to_reg_o = 1'b0;
        err_o        = 1'b0;
        if (rst_i) begin
            err_o = 1'b0;
        end else begin
            case (state_r)
                ST_FETCH: begin
                    mem_req_o   = 1'b1;
                    alu_src_b_o = SRC_B_TWO;
                    alu_ctrl_o  = ALU_ADD;
                    ir_write_o  = mem_ready_i;
                    pc_write_o  = mem_ready_i;
                end
                ST_DECODE: begin
                    alu_src_b_o = SRC_B_IMM_SH;
                    alu_ctrl_o  = ALU_ADD;
                end
                ST_EXEC_R: begin
                    alu_src_a_o = 1'b1;
                    alu_ctrl_o  = dec_alu_s;
                end
                ST_WB_R: begin
                    reg_write_o = 1'b1;
                    reg_dst_o   = 1'b1;
                end
                ST_EXEC_I, ST_ADDR: begin
                    alu_src_a_o = 1'b1;
                    alu_src_b_o = SRC_B_IMM;
                    alu_ctrl_o  = ALU_ADD;
                end
                ST_WB_I:   reg_write_o = 1'b1;
                ST_MEM_RD: begin
                    mem_req_o = 1'b1;
                    iord_o    = 1'b1;
                end
                ST_WB_MEM: begin
                    reg_write_o  = 1'b1;
                    mem_to_reg_o = 1'b1;
                end
                ST_MEM_WR: begin
                    mem_req_o = 1'b1;
                    mem_we_o  = 1'b1;
                    iord_o    = 1'b1;
                end
                ST_BRANCH: begin
                    alu_src_a_o = 1'b1;
                    alu_ctrl_o  = ALU_SUB;
                    pc_src_o    = PC_SRC_ALUOUT;
                    pc_write_o  = zero_i;
                end
                ST_JUMP: begin
                    pc_src_o   = PC_SRC_JUMP;
                    pc_write_o = 1'b1;
                end
                ST_ILLEGAL: err_o = 1'b1;
                default:    err_o = 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl with a 4-bit counter so wrap-around is reachable.
module tb_mc_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [3:0] op_i;
    logic [2:0] funct_i;
    logic       zero_i;
    logic       mem_ready_i;
    logic       mem_req_o, mem_we_o, iord_o, ir_write_o, pc_write_o;
    logic [1:0] pc_src_o, alu_src_b_o;
    logic       alu_src_a_o;
    logic [3:0] alu_ctrl_o;
    logic       reg_write_o, reg_dst_o, mem_to_reg_o, err_o;
    logic [3:0] instr_cnt_o;

    int n_checks = 0;
    int n_errors = 0;

    mc_ctrl #(.CNT_W(4)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .op_i         (op_i),
        .funct_i      (funct_i),
        .zero_i       (zero_i),
        .mem_ready_i  (mem_ready_i),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .iord_o       (iord_o),
        .ir_write_o   (ir_write_o),
        .pc_write_o   (pc_write_o),
        .pc_src_o     (pc_src_o),
        .alu_src_a_o  (alu_src_a_o),
        .alu_src_b_o  (alu_src_b_o),
        .alu_ctrl_o   (alu_ctrl_o),
        .reg_write_o  (reg_write_o),
        .reg_dst_o    (reg_dst_o),
        .mem_to_reg_o (mem_to_reg_o),
        .err_o        (err_o),
        .instr_cnt_o  (instr_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Packs all control outputs: mreq we iord irw pcw pcsrc[2] a b[2] alu[4] rw rd m2r err
    task automatic ctl(input string tag, input logic mreq, input logic we, input logic iord,
                       input logic irw, input logic pcw, input logic [1:0] pcs, input logic a,
                       input logic [1:0] b, input logic [3:0] alu, input logic rw,
                       input logic rd, input logic m2r, input logic err);
        logic [17:0] obs, exp;
        obs = {mem_req_o, mem_we_o, iord_o, ir_write_o, pc_write_o, pc_src_o, alu_src_a_o,
               alu_src_b_o, alu_ctrl_o, reg_write_o, reg_dst_o, mem_to_reg_o, err_o};
        exp = {mreq, we, iord, irw, pcw, pcs, a, b, alu, rw, rd, m2r, err};
        check_eq(tag, 32'(obs), 32'(exp));
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // FETCH with ready high followed by DECODE, both checked.
    task automatic fetch_decode(input string tag);
        mem_ready_i = 1'b1;
        #1;
        ctl({tag, "_fetch"}, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 2'b01, 4'b0010,
            1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        ctl({tag, "_decode"}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b11, 4'b0010,
            1'b0, 1'b0, 1'b0, 1'b0);
        tick();
    endtask

    initial begin
        rst_i = 1'b1; op_i = 4'b0000; funct_i = 3'b000; zero_i = 1'b0; mem_ready_i = 1'b0;
        tick(); tick();
        ctl("reset_ctl", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 4'b0000,
            1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("reset_cnt", 32'(instr_cnt_o), 32'd0);

        // lw interrupted by reset while waiting in MEM_RD
        rst_i = 1'b0; op_i = 4'b0010;
        fetch_decode("lwrst");
        mem_ready_i = 1'b0;
        #1;
        ctl("lwrst_addr", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b10, 4'b0010,
            1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        ctl("lwrst_memrd", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 4'b0000,
            1'b0, 1'b0, 1'b0, 1'b0);
        rst_i = 1'b1; mem_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            ctl("rst_hold_ctl", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 4'b0000,
                1'b0, 1'b0, 1'b0, 1'b0);
            tick();
        end
        check_eq("rst_hold_cnt", 32'(instr_cnt_o), 32'd0);
        rst_i = 1'b0; mem_ready_i = 1'b0;
        #1;
        ctl("post_rst_fetch", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b01, 4'b0010,
            1'b0, 1'b0, 1'b0, 1'b0);

        // R-type sub
        op_i = 4'b0000; funct_i = 3'b001;
        fetch_decode("sub");
        ctl("sub_exec", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b00, 4'b0110,
            1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        ctl("sub_wb", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 4'b0000,
            1'b1, 1'b1, 1'b0, 1'b0);
        check_eq("sub_cnt_before", 32'(instr_cnt_o), 32'd0);
        tick();
        check_eq("sub_cnt_after", 32'(instr_cnt_o), 32'd1);

        // lw with three wait cycles in MEM_RD
        op_i = 4'b0010;
        fetch_decode("lw");
        tick();
        mem_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) mem_ready_i = 1'b1;
            #1;
            ctl("lw_memrd", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 4'b0000,
                1'b0, 1'b0, 1'b0, 1'b0);
            tick();
        end
        ctl("lw_wbmem", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 4'b0000,
            1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        check_eq("lw_cnt", 32'(instr_cnt_o), 32'd2);

        // sw
        op_i = 4'b0011;
        fetch_decode("sw");
        tick();
        ctl("sw_memwr", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 4'b0000,
            1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check_eq("sw_cnt", 32'(instr_cnt_o), 32'd3);

        // addi
        op_i = 4'b0001;
        fetch_decode("addi");
        ctl("addi_exec", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b10, 4'b0010,
            1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        ctl("addi_wb", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 4'b0000,
            1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        check_eq("addi_cnt", 32'(instr_cnt_o), 32'd4);

        // beq taken and not taken
        op_i = 4'b0100;
        for (int z = 1; z >= 0; z--) begin
            fetch_decode("beq");
            zero_i = z[0];
            #1;
            ctl("beq_branch", 1'b0, 1'b0, 1'b0, 1'b0, z[0], 2'b01, 1'b1, 2'b00, 4'b0110,
                1'b0, 1'b0, 1'b0, 1'b0);
            tick();
        end
        zero_i = 1'b0;
        check_eq("beq_cnt", 32'(instr_cnt_o), 32'd6);

        // illegal opcode, then R-type with illegal funct
        for (int k = 0; k < 2; k++) begin
            op_i = (k == 0) ? 4'b1010 : 4'b0000;
            funct_i = 3'b111;
            fetch_decode("ill");
            ctl("ill_err", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 4'b0000,
                1'b0, 1'b0, 1'b0, 1'b1);
            tick();
            mem_ready_i = 1'b0;
            #1;
            ctl("ill_back_fetch", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b01, 4'b0010,
                1'b0, 1'b0, 1'b0, 1'b0);
            check_eq("ill_cnt", 32'(instr_cnt_o), 32'd6);
        end

        // counter wrap: reset, then 17 jumps
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0; op_i = 4'b0101;
        for (int j = 1; j <= 17; j++) begin
            fetch_decode("j");
            if (j == 1) begin
                ctl("j_jump", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 2'b00, 4'b0000,
                    1'b0, 1'b0, 1'b0, 1'b0);
            end
            tick();
            if (j == 15) check_eq("wrap_cnt15", 32'(instr_cnt_o), 32'd15);
            if (j == 16) check_eq("wrap_cnt16", 32'(instr_cnt_o), 32'd0);
        end
        check_eq("wrap_cnt17", 32'(instr_cnt_o), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multicycle control FSM for the 16-bit MIPS-style datapath. It is the producer side of the ALU interface: it drives the 4-bit ALU control code and the operand selects, and consumes the ALU zero flag.
- Sequences fetch, decode, execute, memory and writeback phases over a ready-handshaked unified memory.
- Counts retired instructions and flags illegal opcodes.

Parameters:
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; synchronous, active-high.
- op_i  in  4  opcode, from instruction-register bits [15:12].
- funct_i  in  3  R-type function, from instruction-register bits [2:0].
- zero_i  in  1  ALU zero flag.
- mem_ready_i  in  1  memory completes the current request this cycle.
- mem_req_o  out  1  memory request valid.
- mem_we_o  out  1  request is a write.
- iord_o  out  1  address select: 0 = PC, 1 = ALUOut.
- ir_write_o  out  1  load instruction register.
- pc_write_o  out  1  load PC.
- pc_src_o  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- alu_src_a_o  out  1  ALU A select: 0 = PC, 1 = regA.
- alu_src_b_o  out  2  ALU B select: 00 = regB, 01 = constant 2, 10 = sign-extended imm, 11 = sign-extended imm<<1.
- alu_ctrl_o  out  4  ALU control code: 0010 add, 0110 sub, 0111 slt, 0000 pass A.
- reg_write_o  out  1  register-file write enable.
- reg_dst_o  out  1  destination select: 1 = rd, 0 = rt.
- mem_to_reg_o  out  1  writeback select: 1 = memory data, 0 = ALUOut.
- err_o  out  1  one-cycle pulse on illegal opcode.
- instr_cnt_o  out  CNT_W  retired-instruction count.

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - rst_i sampled at the posedge: state <- FETCH, instr_cnt_o <- 0.
  - While rst_i is high, every control output is forced to 0.
  - Reset during any state, including an outstanding memory wait, abandons the operation. No write strobe is issued in the reset cycle.
- Output style: outputs are decoded from the registered state. Write strobes are additionally qualified by mem_ready_i or zero_i where stated. Any output not listed for a state is 0.
- Opcodes:
  - 0000 R-type; funct 000 add, 001 sub, 010 slt; other funct values are illegal.
  - 0001 addi, 0010 lw, 0011 sw, 0100 beq, 0101 j.
  - 0110–1111 are illegal.
- States and transitions:
  - FETCH: mem_req=1, iord=0, src_a=0, src_b=01, alu_ctrl=0010, pc_src=00.
    - ir_write = pc_write = mem_ready_i.
    - Stay in FETCH until mem_ready_i, then go to DECODE.
  - DECODE: src_a=0, src_b=11, alu_ctrl=0010 (branch target into ALUOut). Dispatch on op_i/funct_i:
    - R-type → EXEC_R
    - addi → EXEC_I
    - lw/sw → ADDR
    - beq → BRANCH
    - j → JUMP
    - illegal → ILLEGAL
  - EXEC_R: src_a=1, src_b=00, alu_ctrl from funct (add 0010, sub 0110, slt 0111). Next: WB_R.
  - WB_R: reg_write=1, reg_dst=1, mem_to_reg=0. Retire. Next: FETCH.
  - EXEC_I: src_a=1, src_b=10, alu_ctrl=0010. Next: WB_I.
  - WB_I: reg_write=1, reg_dst=0. Retire. Next: FETCH.
  - ADDR: src_a=1, src_b=10, alu_ctrl=0010. Next: MEM_RD for lw, MEM_WR for sw.
  - MEM_RD: mem_req=1, iord=1. Hold until mem_ready_i, then go to WB_MEM.
  - WB_MEM: reg_write=1, reg_dst=0, mem_to_reg=1. Retire. Next: FETCH.
  - MEM_WR: mem_req=1, mem_we=1, iord=1. Hold until mem_ready_i; on ready, retire and go to FETCH.
  - BRANCH: src_a=1, src_b=00, alu_ctrl=0110, pc_src=01, pc_write=zero_i. Retire. Next: FETCH.
  - JUMP: pc_src=10, pc_write=1. Retire. Next: FETCH.
  - ILLEGAL: err_o=1 for exactly one cycle. No retire. Next: FETCH.
- Memory handshake:
  - mem_req_o and the address select stay stable until the cycle in which mem_ready_i is high.
  - mem_ready_i while mem_req_o=0 is ignored.
- Counter:
  - instr_cnt_o increments by 1 on the retire edge and wraps modulo 2^CNT_W, with no flag on wrap.
- Latency with mem_ready_i tied high, FETCH to next FETCH: R/addi 4 cycles, lw 5, sw 4, beq 3, j 3, illegal 3.

Decomposition:
- Shared package mips_pkg holds:
  - ALU control constants: ALU_ADD=4'b0010, ALU_SUB=4'b0110, ALU_SLT=4'b0111, ALU_PASS=4'b0000.
  - Opcode and funct constants.
  - The state enum.
  - The src_b and pc_src select encodings.
- One sub-module, mc_alu_dec: combinational funct → alu_ctrl map with an illegal flag. Used by DECODE and EXEC_R.

Test Plan:
- Reset held 3 cycles mid-MEM_RD with mem_ready_i=1 → all outputs 0, reg_write never asserted, instr_cnt_o=0; first cycle after release is FETCH with mem_req_o=1.
- R-type sub (op 0000, funct 001), ready tied high → FETCH, DECODE, EXEC_R (alu_ctrl_o=0110), WB_R (reg_write_o=1, reg_dst_o=1); instr_cnt_o 0→1 after 4 cycles.
- lw with mem_ready_i low for 3 cycles in MEM_RD → mem_req_o=1 and iord_o=1 held for 4 cycles; WB_MEM has mem_to_reg_o=1; 8 cycles total.
- beq: zero_i=1 → pc_write_o=1, pc_src_o=01. Repeat with zero_i=0 → pc_write_o=0. Both cases increment instr_cnt_o.
- Op 1010, then R-type with funct 111 → err_o pulses exactly one cycle each, instr_cnt_o unchanged, FSM returns to FETCH.
- Counter wrap with CNT_W=4: retire 17 j instructions → instr_cnt_o reads 1.
